// File: rtl/link_mm_req_bridge.sv
// -----------------------------------------------------------------------------
// link_mm_req_bridge
//
// Bridges an Avalon-MM style host slave port onto the link address decoder.
// Writes are posted at one per cycle. A read is forwarded as a single-cycle
// oMM_RD_EN, and the host is stalled until the decoder returns data. The
// data is then presented to the host with a single-cycle avs_readdatavalid.
// Every output is registered.
//
// Optional feature (macro LINK_MM_BRIDGE_TIMEOUT_EN):
//   When this macro is defined, a read that gets no decoder response within
//   TIMEOUT_CYCLES cycles completes with {32'hDEAD_BEEF, 15'b0, addr}, and
//   oTIMEOUT_CNT is incremented. When it is undefined, a read waits
//   indefinitely, oTIMEOUT_CNT is tied to 0 and no timer is built.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   avs_address         host word address (17 bits)
//   avs_read/avs_write  host commands; when both are set, the write wins
//   avs_writedata       host write data (64 bits)
//   avs_waitrequest     0 in IDLE, 1 while a read is outstanding
//   avs_readdata        read response; holds until the next response
//   avs_readdatavalid   single-cycle read completion strobe
//   oMM_ADDR/oMM_WR_DATA   decoder address and write data (held when idle)
//   oMM_WR_EN/oMM_RD_EN    single-cycle decoder strobes
//   iMM_RD_DATA/_V         decoder read return
//   iERR_CLR            synchronous clear of both error counters
//   oTIMEOUT_CNT        read timeouts seen (saturates at 255)
//   oSTRAY_CNT          decoder responses seen outside RD_WAIT (saturates at 255)
// -----------------------------------------------------------------------------
module link_mm_req_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [16:0] avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [63:0] avs_writedata,
   output logic        avs_waitrequest,
   output logic [63:0] avs_readdata,
   output logic        avs_readdatavalid,
   output logic [16:0] oMM_ADDR,
   output logic [63:0] oMM_WR_DATA,
   output logic        oMM_WR_EN,
   output logic        oMM_RD_EN,
   input  logic [63:0] iMM_RD_DATA,
   input  logic        iMM_RD_DATA_V,
   input  logic        iERR_CLR,
   output logic [7:0]  oTIMEOUT_CNT,
   output logic [7:0]  oSTRAY_CNT
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
      $error("TIMEOUT_CYCLES must be in 2..65535");
   end

   typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

   state_e      r_state;
   state_e      w_state_nxt;

   logic        w_wr_cmd;
   logic        w_rd_cmd;
   logic        w_rsp_ok;
   logic        w_timeout;
   logic        w_stray;

   logic [16:0] r_mm_addr;
   logic [63:0] r_mm_wr_data;
   logic        r_mm_wr_en;
   logic        r_mm_rd_en;
   logic [63:0] r_rdata;
   logic        r_rvalid;
   logic        r_waitreq;
   logic [7:0]  r_stray_cnt;

   logic [16:0] w_mm_addr_nxt;
   logic [63:0] w_mm_wr_data_nxt;
   logic        w_mm_wr_en_nxt;
   logic        w_mm_rd_en_nxt;
   logic [63:0] w_rdata_nxt;
   logic        w_rvalid_nxt;
   logic        w_waitreq_nxt;
   logic [7:0]  w_stray_cnt_nxt;

   // Commands are only accepted in IDLE, the only state where waitrequest is low.
   assign w_wr_cmd = (r_state == StIdle) && avs_write;
   assign w_rd_cmd = (r_state == StIdle) && avs_read && !avs_write;
   assign w_rsp_ok = (r_state == StRdWait) && iMM_RD_DATA_V;
   assign w_stray  = (r_state != StRdWait) && iMM_RD_DATA_V;

`ifdef LINK_MM_BRIDGE_TIMEOUT_EN
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_timer;
   logic [7:0]  r_timeout_cnt;
   logic [7:0]  w_timeout_cnt_nxt;

   // Valid data in the timeout cycle takes precedence over the timeout.
   assign w_timeout = (r_state == StRdWait) && !iMM_RD_DATA_V && (r_timer == TimeoutLast);

   // Held at zero outside RD_WAIT, so each read starts counting from 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
      end else if (r_state != StRdWait) begin
         r_timer <= '0;
      end else if (r_timer != TimeoutLast) begin
         r_timer <= r_timer + 16'd1;
      end
   end

   always_comb begin
      w_timeout_cnt_nxt = r_timeout_cnt;
      if (iERR_CLR) begin
         w_timeout_cnt_nxt = '0;
      end else if (w_timeout && (r_timeout_cnt != 8'hFF)) begin
         w_timeout_cnt_nxt = r_timeout_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout_cnt <= '0;
      end else begin
         r_timeout_cnt <= w_timeout_cnt_nxt;
      end
   end

   assign oTIMEOUT_CNT = r_timeout_cnt;
`else
   assign w_timeout    = 1'b0;
   assign oTIMEOUT_CNT = 8'd0;
`endif

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_rd_cmd) begin
               w_state_nxt = StRdWait;
            end
         end
         StRdWait: begin
            if (w_rsp_ok || w_timeout) begin
               w_state_nxt = StResp;
            end
         end
         StResp: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs (next values of the output registers)
   // ---------------------------------------------------------------------------
   always_comb begin
      w_mm_addr_nxt    = r_mm_addr;
      w_mm_wr_data_nxt = r_mm_wr_data;
      w_mm_wr_en_nxt   = w_wr_cmd;
      w_mm_rd_en_nxt   = w_rd_cmd;
      w_rdata_nxt      = r_rdata;

      if (w_wr_cmd || w_rd_cmd) begin
         w_mm_addr_nxt = avs_address;
      end
      if (w_wr_cmd) begin
         w_mm_wr_data_nxt = avs_writedata;
      end

      // r_mm_addr still holds the read address: no command is accepted in RD_WAIT.
      if (w_rsp_ok) begin
         w_rdata_nxt = iMM_RD_DATA;
      end else if (w_timeout) begin
         w_rdata_nxt = {32'hDEAD_BEEF, 15'b0, r_mm_addr};
      end

      // Registered from the next state so these line up with r_state.
      w_rvalid_nxt  = (w_state_nxt == StResp);
      w_waitreq_nxt = (w_state_nxt != StIdle);
   end

   always_comb begin
      w_stray_cnt_nxt = r_stray_cnt;
      if (iERR_CLR) begin
         w_stray_cnt_nxt = '0;
      end else if (w_stray && (r_stray_cnt != 8'hFF)) begin
         w_stray_cnt_nxt = r_stray_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mm_addr    <= '0;
         r_mm_wr_data <= '0;
         r_mm_wr_en   <= 1'b0;
         r_mm_rd_en   <= 1'b0;
         r_rdata      <= '0;
         r_rvalid     <= 1'b0;
         r_waitreq    <= 1'b0;
         r_stray_cnt  <= '0;
      end else begin
         r_mm_addr    <= w_mm_addr_nxt;
         r_mm_wr_data <= w_mm_wr_data_nxt;
         r_mm_wr_en   <= w_mm_wr_en_nxt;
         r_mm_rd_en   <= w_mm_rd_en_nxt;
         r_rdata      <= w_rdata_nxt;
         r_rvalid     <= w_rvalid_nxt;
         r_waitreq    <= w_waitreq_nxt;
         r_stray_cnt  <= w_stray_cnt_nxt;
      end
   end

   assign avs_waitrequest   = r_waitreq;
   assign avs_readdata      = r_rdata;
   assign avs_readdatavalid = r_rvalid;
   assign oMM_ADDR          = r_mm_addr;
   assign oMM_WR_DATA       = r_mm_wr_data;
   assign oMM_WR_EN         = r_mm_wr_en;
   assign oMM_RD_EN         = r_mm_rd_en;
   assign oSTRAY_CNT        = r_stray_cnt;

endmodule

// File: tb/tb_link_mm_req_bridge.sv
// -----------------------------------------------------------------------------
// tb_link_mm_req_bridge
//
// Self-checking bench for link_mm_req_bridge. The bench acts as both the host
// and the decoder. Expected values come from a transaction-level model:
// the last write or read address and data, the last response, and the
// saturating error counts. Timeout checks are built only when
// LINK_MM_BRIDGE_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_link_mm_req_bridge;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [16:0] avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [63:0] avs_writedata = '0;
   logic        avs_waitrequest;
   logic [63:0] avs_readdata;
   logic        avs_readdatavalid;
   logic [16:0] mm_addr;
   logic [63:0] mm_wr_data;
   logic        mm_wr_en;
   logic        mm_rd_en;
   logic [63:0] mm_rd_data = '0;
   logic        mm_rd_data_v = 1'b0;
   logic        err_clr = 1'b0;
   logic [7:0]  timeout_cnt;
   logic [7:0]  stray_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model of the observable state
   logic [16:0] exp_addr  = '0;
   logic [63:0] exp_wdata = '0;
   logic [63:0] exp_rdata = '0;
   int          exp_stray = 0;
   int          exp_tmo   = 0;

   logic [16:0] ra;
   logic [63:0] rd;
   int          dly;

   link_mm_req_bridge #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .avs_address       (avs_address),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_waitrequest   (avs_waitrequest),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .oMM_ADDR          (mm_addr),
      .oMM_WR_DATA       (mm_wr_data),
      .oMM_WR_EN         (mm_wr_en),
      .oMM_RD_EN         (mm_rd_en),
      .iMM_RD_DATA       (mm_rd_data),
      .iMM_RD_DATA_V     (mm_rd_data_v),
      .iERR_CLR          (err_clr),
      .oTIMEOUT_CNT      (timeout_cnt),
      .oSTRAY_CNT        (stray_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic chk_counters(input string tag);
      chk({tag, ".stray"}, 64'(stray_cnt), 64'(sat(exp_stray)));
      chk({tag, ".tmo"}, 64'(timeout_cnt), 64'(sat(exp_tmo)));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".waitreq"}, 64'(avs_waitrequest), 64'd0);
      chk({tag, ".rvalid"}, 64'(avs_readdatavalid), 64'd0);
      chk({tag, ".rdata"}, avs_readdata, 64'd0);
      chk({tag, ".wr_en"}, 64'(mm_wr_en), 64'd0);
      chk({tag, ".rd_en"}, 64'(mm_rd_en), 64'd0);
      chk({tag, ".addr"}, 64'(mm_addr), 64'd0);
      chk({tag, ".wdata"}, mm_wr_data, 64'd0);
      chk({tag, ".tmo"}, 64'(timeout_cnt), 64'd0);
      chk({tag, ".stray"}, 64'(stray_cnt), 64'd0);
   endtask

   // Presents one write for one cycle. The caller drops avs_write afterwards,
   // which allows back-to-back bursts.
   task automatic do_write(input string tag, input logic [16:0] a, input logic [63:0] d);
      avs_write     = 1'b1;
      avs_address   = a;
      avs_writedata = d;
      tick();
      exp_addr  = a;
      exp_wdata = d;
      chk({tag, ".wr_en"}, 64'(mm_wr_en), 64'd1);
      chk({tag, ".rd_en"}, 64'(mm_rd_en), 64'd0);
      chk({tag, ".addr"}, 64'(mm_addr), 64'(exp_addr));
      chk({tag, ".wdata"}, mm_wr_data, exp_wdata);
      chk({tag, ".waitreq"}, 64'(avs_waitrequest), 64'd0);
   endtask

   // Host read. The decoder answers in the cycle that is 'delay' cycles
   // after oMM_RD_EN, and completion is expected one cycle later.
   task automatic do_read(input string tag, input logic [16:0] a, input int delay,
                          input logic [63:0] d);
      avs_read    = 1'b1;
      avs_write   = 1'b0;
      avs_address = a;
      tick();
      avs_read = 1'b0;
      exp_addr = a;
      chk({tag, ".rd_en"}, 64'(mm_rd_en), 64'd1);
      chk({tag, ".wr_en"}, 64'(mm_wr_en), 64'd0);
      chk({tag, ".addr"}, 64'(mm_addr), 64'(exp_addr));
      chk({tag, ".waitreq"}, 64'(avs_waitrequest), 64'd1);
      chk({tag, ".rvalid0"}, 64'(avs_readdatavalid), 64'd0);
      for (int i = 0; i < delay; i++) begin
         tick();
         chk({tag, ".wait_wr"}, 64'(avs_waitrequest), 64'd1);
         chk({tag, ".wait_rd_en"}, 64'(mm_rd_en), 64'd0);
         chk({tag, ".wait_rvalid"}, 64'(avs_readdatavalid), 64'd0);
      end
      mm_rd_data_v = 1'b1;
      mm_rd_data   = d;
      tick();
      mm_rd_data_v = 1'b0;
      mm_rd_data   = {$urandom, $urandom};
      exp_rdata    = d;
      chk({tag, ".rvalid"}, 64'(avs_readdatavalid), 64'd1);
      chk({tag, ".rdata"}, avs_readdata, exp_rdata);
      chk({tag, ".resp_waitreq"}, 64'(avs_waitrequest), 64'd1);
      tick();
      chk({tag, ".rvalid_end"}, 64'(avs_readdatavalid), 64'd0);
      chk({tag, ".idle_waitreq"}, 64'(avs_waitrequest), 64'd0);
      chk({tag, ".rdata_hold"}, avs_readdata, exp_rdata);
      chk_counters(tag);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick();
      chk_reset_outputs("post_reset");

      // Single write, then the address and data hold while idle
      do_write("wr1", 17'h08010, 64'h1122_3344_5566_7788);
      avs_write = 1'b0;
      tick();
      chk("wr1.pulse_end", 64'(mm_wr_en), 64'd0);
      chk("wr1.addr_hold", 64'(mm_addr), 64'(exp_addr));
      chk("wr1.wdata_hold", mm_wr_data, exp_wdata);
      chk("wr1.waitreq", 64'(avs_waitrequest), 64'd0);

      // Directed read with a 3-cycle decoder latency
      do_read("rd1", 17'h10004, 3, 64'hCAFE_0000_0000_0001);

      // Four back-to-back writes followed by a read
      for (int i = 0; i < 4; i++) begin
         do_write($sformatf("burst%0d", i), 17'($urandom), {$urandom, $urandom});
      end
      avs_write = 1'b0;
      do_read("burst_rd", 17'($urandom), 0, {$urandom, $urandom});

      // Read and write together: only the write happens
      avs_read = 1'b1;
      do_write("rw", 17'($urandom), {$urandom, $urandom});
      avs_read  = 1'b0;
      avs_write = 1'b0;
      tick();
      chk("rw.rd_en", 64'(mm_rd_en), 64'd0);
      chk("rw.wr_en", 64'(mm_wr_en), 64'd0);
      chk("rw.waitreq", 64'(avs_waitrequest), 64'd0);
      tick();
      chk("rw.still_idle", 64'(avs_waitrequest), 64'd0);
      chk("rw.no_rvalid", 64'(avs_readdatavalid), 64'd0);

      // Randomized mix of write bursts and reads
      for (int t = 0; t < 8; t++) begin
         if ($urandom_range(1, 0) == 0) begin
            for (int i = 0; i < int'($urandom_range(3, 1)); i++) begin
               do_write($sformatf("mix%0d_wr", t), 17'($urandom), {$urandom, $urandom});
            end
            avs_write = 1'b0;
            tick();
            chk("mix.wr_idle", 64'(mm_wr_en), 64'd0);
            chk("mix.wdata_hold", mm_wr_data, exp_wdata);
         end else begin
            dly = int'($urandom_range(6, 0));
            do_read($sformatf("mix%0d_rd", t), 17'($urandom), dly, {$urandom, $urandom});
         end
      end

      // Stray responses in IDLE: counted, data ignored, saturation at 255
      mm_rd_data_v = 1'b1;
      mm_rd_data   = {$urandom, $urandom};
      tick();
      exp_stray++;
      chk_counters("stray1");
      chk("stray1.rdata", avs_readdata, exp_rdata);
      chk("stray1.rvalid", 64'(avs_readdatavalid), 64'd0);
      repeat (260) tick();
      exp_stray += 260;
      chk_counters("stray_sat");
      err_clr = 1'b1;
      tick();
      exp_stray = 0;
      exp_tmo   = 0;
      chk_counters("clr_prio");
      err_clr = 1'b0;
      tick();
      exp_stray++;
      chk_counters("stray_after_clr");
      mm_rd_data_v = 1'b0;
      err_clr      = 1'b1;
      tick();
      err_clr   = 1'b0;
      exp_stray = 0;
      chk_counters("clr");

`ifdef LINK_MM_BRIDGE_TIMEOUT_EN
      // Read with no response: times out after TO cycles in RD_WAIT
      avs_read    = 1'b1;
      avs_address = 17'h1FFFF;
      tick();
      avs_read = 1'b0;
      exp_addr = 17'h1FFFF;
      chk("tmo.rd_en", 64'(mm_rd_en), 64'd1);
      for (int i = 1; i < int'(TO); i++) begin
         tick();
         chk("tmo.wait_rvalid", 64'(avs_readdatavalid), 64'd0);
         chk("tmo.wait_waitreq", 64'(avs_waitrequest), 64'd1);
      end
      tick();
      exp_rdata = (64'hDEAD_BEEF << 32) | 64'(exp_addr);
      exp_tmo++;
      chk("tmo.rvalid", 64'(avs_readdatavalid), 64'd1);
      chk("tmo.rdata", avs_readdata, exp_rdata);
      chk_counters("tmo");
      tick();
      chk("tmo.rvalid_end", 64'(avs_readdatavalid), 64'd0);
      mm_rd_data_v = 1'b1;
      tick();
      mm_rd_data_v = 1'b0;
      exp_stray++;
      chk_counters("tmo_late");
      chk("tmo_late.rdata", avs_readdata, exp_rdata);

      // Data arriving in the timeout cycle wins over the timeout
      do_read("tmo_edge", 17'($urandom), int'(TO) - 1, {$urandom, $urandom});

      err_clr = 1'b1;
      tick();
      err_clr   = 1'b0;
      exp_stray = 0;
      exp_tmo   = 0;
      chk_counters("tmo_clr");
`else
      // A long-latency read still completes; no timeout is ever counted
      do_read("long_rd", 17'($urandom), int'(TO) + 8, {$urandom, $urandom});
`endif

      // Reset two cycles into RD_WAIT
      ra = 17'($urandom);
      avs_read    = 1'b1;
      avs_address = ra;
      tick();
      avs_read = 1'b0;
      chk("rst_rd.rd_en", 64'(mm_rd_en), 64'd1);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      exp_addr  = '0;
      exp_wdata = '0;
      exp_rdata = '0;
      exp_stray = 0;
      exp_tmo   = 0;
      chk_reset_outputs("async_rst");
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_rd.no_rvalid", 64'(avs_readdatavalid), 64'd0);
         chk("rst_rd.waitreq", 64'(avs_waitrequest), 64'd0);
      end
      mm_rd_data_v = 1'b1;
      rd           = {$urandom, $urandom};
      mm_rd_data   = rd;
      tick();
      mm_rd_data_v = 1'b0;
      exp_stray++;
      chk_counters("rst_late");
      chk("rst_late.rvalid", 64'(avs_readdatavalid), 64'd0);
      chk("rst_late.rdata", avs_readdata, 64'd0);
      do_read("after_rst", 17'($urandom), 2, {$urandom, $urandom});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
